// File: rtl/board_grid_ctrl.sv
// board_grid_ctrl: game-board controller with a video overlay.
// Decodes the cursor into a grid cell and turns mouse clicks into moves.
// Keeps an occupancy array of 2 bits per cell ({occupied, player}).
// Fills occupied cells in the video stream with the owner's colour.
//
// Ports:
//   pclk, rst_n                              pixel clock, async active-low reset
//   hcount_in/vcount_in, *sync_in, *blnk_in  timing in
//   rgb_in                                   upstream pixel colour
//   xpos, ypos, mouse_left                   cursor position and left button
//   start_en, clear                          game active, synchronous board clear
//   *_out                                    video delayed by 2 pclk cycles
//   move_valid, move_cell, move_player       last accepted move
//   turn, board_full                         game status
//
// Optional feature macro: HOVER_HIGHLIGHT_EN. When defined, an empty cell
// under the cursor is lightened while start_en=1.
module board_grid_ctrl #(
  parameter int unsigned GRID_N  = 3,
  parameter int unsigned CELL_W  = 336,
  parameter int unsigned CELL_H  = 250,
  parameter int unsigned GAP     = 6,
  parameter logic [11:0] X_COLOR = 12'hF00,
  parameter logic [11:0] O_COLOR = 12'h00F
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        start_en,
  input  logic        clear,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        move_valid,
  output logic [3:0]  move_cell,
  output logic        move_player,
  output logic        turn,
  output logic        board_full
);

  localparam int unsigned NCELLS = GRID_N * GRID_N;

  // One axis: {hit, index}. A coordinate in a gap or past the last cell misses.
  function automatic logic [2:0] axis_hit(input int unsigned p, input int unsigned sz);
    axis_hit = '0;
    for (int unsigned c = 0; c < GRID_N; c++) begin
      if (p >= c * (sz + GAP) && p <= c * (sz + GAP) + sz - 1)
        axis_hit = {1'b1, 2'(c)};
    end
  endfunction

  // Both axes: {hit, row-major cell index}.
  function automatic logic [4:0] cell_hit(input int unsigned x, input int unsigned y);
    logic [2:0] col;
    logic [2:0] row;
    col = axis_hit(x, CELL_W);
    row = axis_hit(y, CELL_H);
    cell_hit = {col[2] & row[2], 4'(32'(row[1:0]) * GRID_N + 32'(col[1:0]))};
  endfunction

  function automatic logic [1:0] occ_at(input logic [NCELLS-1:0][1:0] occ,
                                        input logic [3:0] idx);
    occ_at = '0;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      if (4'(i) == idx) occ_at = occ[i];
    end
  endfunction

  // Control state
  logic [NCELLS-1:0][1:0] occ_q, occ_d;
  logic       turn_q, turn_d;
  logic       full_q, full_d;
  logic       move_valid_q, move_valid_d;
  logic [3:0] move_cell_q, move_cell_d;
  logic       move_player_q, move_player_d;
  logic       mouse_q, mouse_d;
  // armed_q blocks a false click on the first edge after reset release
  logic       armed_q, armed_d;

  // Video stage 1
  logic [10:0] h1_q, v1_q;
  logic        hs1_q, vs1_q, hb1_q, vb1_q;
  logic [11:0] rgb1_q;
  logic        pix_hit1_q;
  logic [3:0]  pix_idx1_q;
`ifdef HOVER_HIGHLIGHT_EN
  logic        hover1_q;
`endif

  // Video stage 2 (outputs)
  logic [10:0] h2_q, v2_q;
  logic        hs2_q, vs2_q, hb2_q, vb2_q;
  logic [11:0] rgb2_q, rgb2_d;

  logic [4:0] cur_c;
  logic [4:0] pix_c;
  logic [1:0] cur_occ_c;
  logic [1:0] pix_occ_c;
  logic       click_c;
  logic       accept_c;

  // Cursor decode and click qualification
  always_comb begin
    cur_c     = cell_hit(32'(xpos), 32'(ypos));
    pix_c     = cell_hit(32'(hcount_in), 32'(vcount_in));
    cur_occ_c = occ_at(occ_q, cur_c[3:0]);
    click_c   = mouse_left & ~mouse_q & armed_q;
    accept_c  = click_c & start_en & ~clear & ~full_q & cur_c[4] & ~cur_occ_c[1];
  end

  // Game next-state
  always_comb begin
    occ_d         = occ_q;
    turn_d        = turn_q;
    full_d        = full_q;
    move_valid_d  = 1'b0;
    move_cell_d   = move_cell_q;
    move_player_d = move_player_q;
    mouse_d       = mouse_left;
    armed_d       = 1'b1;
    if (clear) begin
      occ_d  = '0;
      turn_d = 1'b0;
      full_d = 1'b0;
    end else if (accept_c) begin
      for (int unsigned i = 0; i < NCELLS; i++) begin
        if (4'(i) == cur_c[3:0]) occ_d[i] = {1'b1, turn_q};
      end
      turn_d        = ~turn_q;
      move_valid_d  = 1'b1;
      move_cell_d   = cur_c[3:0];
      move_player_d = turn_q;
      full_d        = 1'b1;
      for (int unsigned i = 0; i < NCELLS; i++) full_d = full_d & occ_d[i][1];
    end
  end

  // Stage 2 colour: owner colour inside visible occupied cells
  always_comb begin
    pix_occ_c = occ_at(occ_q, pix_idx1_q);
    rgb2_d    = rgb1_q;
    if (pix_hit1_q && pix_occ_c[1] && !hb1_q && !vb1_q) begin
      rgb2_d = pix_occ_c[0] ? O_COLOR : X_COLOR;
    end
`ifdef HOVER_HIGHLIGHT_EN
    else if (hover1_q && pix_hit1_q && !pix_occ_c[1]) begin
      rgb2_d = rgb1_q | 12'h888;
    end
`endif
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q         <= '0;
      turn_q        <= 1'b0;
      full_q        <= 1'b0;
      move_valid_q  <= 1'b0;
      move_cell_q   <= '0;
      move_player_q <= 1'b0;
      mouse_q       <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      occ_q         <= occ_d;
      turn_q        <= turn_d;
      full_q        <= full_d;
      move_valid_q  <= move_valid_d;
      move_cell_q   <= move_cell_d;
      move_player_q <= move_player_d;
      mouse_q       <= mouse_d;
      armed_q       <= armed_d;
    end
  end

  // Two-stage video pipeline
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q       <= '0;
      v1_q       <= '0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      hb1_q      <= 1'b0;
      vb1_q      <= 1'b0;
      rgb1_q     <= '0;
      pix_hit1_q <= 1'b0;
      pix_idx1_q <= '0;
`ifdef HOVER_HIGHLIGHT_EN
      hover1_q   <= 1'b0;
`endif
      h2_q       <= '0;
      v2_q       <= '0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      hb2_q      <= 1'b0;
      vb2_q      <= 1'b0;
      rgb2_q     <= '0;
    end else begin
      h1_q       <= hcount_in;
      v1_q       <= vcount_in;
      hs1_q      <= hsync_in;
      vs1_q      <= vsync_in;
      hb1_q      <= hblnk_in;
      vb1_q      <= vblnk_in;
      rgb1_q     <= rgb_in;
      pix_hit1_q <= pix_c[4];
      pix_idx1_q <= pix_c[3:0];
`ifdef HOVER_HIGHLIGHT_EN
      hover1_q   <= start_en & cur_c[4] & (cur_c[3:0] == pix_c[3:0]);
`endif
      h2_q       <= h1_q;
      v2_q       <= v1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      hb2_q      <= hb1_q;
      vb2_q      <= vb1_q;
      rgb2_q     <= rgb2_d;
    end
  end

  assign hcount_out  = h2_q;
  assign vcount_out  = v2_q;
  assign hsync_out   = hs2_q;
  assign vsync_out   = vs2_q;
  assign hblnk_out   = hb2_q;
  assign vblnk_out   = vb2_q;
  assign rgb_out     = rgb2_q;
  assign move_valid  = move_valid_q;
  assign move_cell   = move_cell_q;
  assign move_player = move_player_q;
  assign turn        = turn_q;
  assign board_full  = full_q;

endmodule
